// File: rtl/uart_pkt_rx.sv
// ============================================================================
// Module   : uart_pkt_rx
// Brief    : SOF/LEN/payload/XOR-checksum frame decoder behind a UART byte
//            receiver; good payloads stream out on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_rx #(
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter int          TIMEOUT_CLKS = 8680
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_d_i,
    input  logic       rx_done_i,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic       err_len_o,
    output logic       err_chk_o,
    output logic       err_timeout_o,
    output logic       err_drop_o,
    output logic       busy_o
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [TW-1:0] C_TMAX    = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    C_MAX_LEN = 8'(MAX_LEN);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_len_q, err_len_d;
    logic          err_chk_q, err_chk_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_drop_q, err_drop_d;
    logic          busy_q;
    logic [7:0]    pbuf_q [MAX_LEN];

    logic w_len_ok;
    logic w_in_frame;
    logic w_buf_we;

    assign w_len_ok   = (rx_d_i != 8'd0) && (rx_d_i <= C_MAX_LEN);
    assign w_in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign w_buf_we   = (state_q == S_PAYLOAD) && rx_done_i;

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_HUNT;
            len_q         <= '0;
            widx_q        <= '0;
            ridx_q        <= '0;
            chk_q         <= '0;
            timer_q       <= '0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_drop_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            widx_q        <= widx_d;
            ridx_q        <= ridx_d;
            chk_q         <= chk_d;
            timer_q       <= timer_d;
            err_len_q     <= err_len_d;
            err_chk_q     <= err_chk_d;
            err_timeout_q <= err_timeout_d;
            err_drop_q    <= err_drop_d;
            busy_q        <= (state_d != S_HUNT);
        end
    end

    // Payload storage carries no reset; entries are only read after being written.
    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_buf
            always_ff @(posedge clk) begin
                if (w_buf_we && (widx_q == IW'(i))) begin
                    pbuf_q[i] <= rx_d_i;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        widx_d        = widx_q;
        ridx_d        = ridx_q;
        chk_d         = chk_q;
        timer_d       = '0;
        err_len_d     = 1'b0;
        err_chk_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_drop_d    = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (rx_done_i && (rx_d_i == SOF_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_done_i) begin
                    if (w_len_ok) begin
                        len_d   = rx_d_i[IW-1:0];
                        chk_d   = rx_d_i;
                        widx_d  = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_done_i) begin
                    chk_d  = chk_q ^ rx_d_i;
                    widx_d = widx_q + 1'b1;
                    if (widx_q == (len_q - 1'b1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_done_i) begin
                    if (rx_d_i == chk_q) begin
                        ridx_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                err_drop_d = rx_done_i;
                if (m_valid_o && m_ready_i) begin
                    ridx_d = ridx_q + 1'b1;
                    if (m_last_o) begin
                        ridx_d  = '0;
                        state_d = S_HUNT;
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // A strobe on the expiry cycle takes priority over the timeout.
        if (w_in_frame && !rx_done_i) begin
            if (timer_q == C_TMAX) begin
                err_timeout_d = 1'b1;
                state_d       = S_HUNT;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        m_valid_o = 1'b0;
        m_data_o  = 8'd0;
        m_last_o  = 1'b0;
        if (state_q == S_DRAIN) begin
            m_valid_o = 1'b1;
            m_data_o  = pbuf_q[ridx_q[AW-1:0]];
            m_last_o  = (ridx_q == (len_q - 1'b1));
        end
    end

    assign err_len_o     = err_len_q;
    assign err_chk_o     = err_chk_q;
    assign err_timeout_o = err_timeout_q;
    assign err_drop_o    = err_drop_q;
    assign busy_o        = busy_q;

endmodule

`default_nettype wire
